// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parametrised serial pattern detector.
//   state_t     : detector FSM states (2-bit encoding)
//   fill_width  : width of a counter that must hold 0..n inclusive
//   match_fn    : masked compare of history against pattern
package seq_det_pkg;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        FILL     = 2'd1,
        HUNT     = 2'd2,
        LOCKED   = 2'd3
    } state_t;

    // Fill counter width: FW = clog2(N+1), so that the value N itself fits.
    function automatic int fill_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Operands are zero-extended to 32 bits by the caller; the unused upper
    // bits of mask are zero and therefore never affect the result.
    function automatic logic match_fn(input logic [31:0] hist,
                                      input logic [31:0] pattern,
                                      input logic [31:0] mask);
        return ((hist ^ pattern) & mask) == 32'd0;
    endfunction

endpackage

// File: rtl/seq_det_shift.sv
// History shift register with saturating fill counter.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   shift_en_i   : consume x_i this cycle
//   clr_i        : clear history and fill (wins over shift_en_i)
//   x_i          : serial data bit
//   hist_nx_o    : history as it looks after shifting x_i in
//   full_nx_o    : fill count reaches N after shifting x_i in
// The post-shift views let the parent evaluate a match on the beat being
// consumed and register the result on the same edge.
module seq_det_shift #(
    parameter int N  = 4,
    parameter int FW = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         shift_en_i,
    input  logic         clr_i,
    input  logic         x_i,
    output logic [N-1:0] hist_nx_o,
    output logic         full_nx_o
);

    localparam logic [FW-1:0] FILL_MAX = FW'(N);

    logic [N-1:0]  hist_q;
    logic [FW-1:0] fill_q;
    logic [FW-1:0] fill_inc;

    // Newest bit enters at hist[0].
    assign hist_nx_o = {hist_q[N-2:0], x_i};
    assign fill_inc  = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + 1'b1;
    assign full_nx_o = (fill_inc == FILL_MAX);

    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (shift_en_i) begin
            hist_q <= hist_nx_o;
            fill_q <= fill_inc;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   in_valid, x  : qualified serial input bit
//   cfg_load     : strobe latching cfg_pattern/mask/overlap/limit, arms detector
//   cfg_pattern  : pattern, bit N-1 received first
//   cfg_mask     : 1 = compare position, 0 = don't care
//   cfg_overlap  : 1 = overlapping matches, 0 = restart fill after a match
//   cfg_limit    : matches before lock-out, 0 = unlimited
//   rearm        : strobe clearing counter, history and lock
//   y            : registered one-cycle match pulse
//   match_cnt    : saturating match count since load/rearm
//   locked       : detector in LOCKED
//   armed        : detector in FILL or HUNT
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic          x,
    input  logic          cfg_load,
    input  logic [N-1:0]  cfg_pattern,
    input  logic [N-1:0]  cfg_mask,
    input  logic          cfg_overlap,
    input  logic [CW-1:0] cfg_limit,
    input  logic          rearm,
    output logic          y,
    output logic [CW-1:0] match_cnt,
    output logic          locked,
    output logic          armed
);

    localparam int FW = fill_width(N);

    state_t        state_q, state_d;
    logic [N-1:0]  pattern_q, mask_q;
    logic          overlap_q;
    logic [CW-1:0] limit_q;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          y_q, y_d;

    logic          shift_en, hist_clr;
    logic [N-1:0]  hist_nx;
    logic          full_nx;
    logic          hit;

    seq_det_shift #(
        .N  (N),
        .FW (FW)
    ) u_shift (
        .clk        (clk),
        .reset      (reset),
        .shift_en_i (shift_en),
        .clr_i      (hist_clr),
        .x_i        (x),
        .hist_nx_o  (hist_nx),
        .full_nx_o  (full_nx)
    );

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign hit     = full_nx && match_fn(32'(hist_nx), 32'(pattern_q), 32'(mask_q));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        y_d      = 1'b0;
        shift_en = 1'b0;
        hist_clr = 1'b0;

        if (cfg_load) begin
            hist_clr = 1'b1;
            cnt_d    = '0;
            state_d  = FILL;
        end else if (rearm && (state_q != DISABLED)) begin
            hist_clr = 1'b1;
            cnt_d    = '0;
            state_d  = FILL;
        end else if (in_valid && ((state_q == FILL) || (state_q == HUNT))) begin
            shift_en = 1'b1;
            if (hit) begin
                y_d   = 1'b1;
                cnt_d = cnt_inc;
                // Lock-out takes precedence over the overlap rule.
                if ((limit_q != '0) && (cnt_inc == limit_q)) begin
                    state_d = LOCKED;
                end else if (!overlap_q) begin
                    // Restart from an empty window; clear wins over the shift.
                    hist_clr = 1'b1;
                    state_d  = FILL;
                end else begin
                    state_d = HUNT;
                end
            end else if (full_nx) begin
                state_d = HUNT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= DISABLED;
            pattern_q <= '0;
            mask_q    <= '0;
            overlap_q <= 1'b0;
            limit_q   <= '0;
            cnt_q     <= '0;
            y_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            if (cfg_load) begin
                pattern_q <= cfg_pattern;
                mask_q    <= cfg_mask;
                overlap_q <= cfg_overlap;
                limit_q   <= cfg_limit;
            end
        end
    end

    assign y         = y_q;
    assign match_cnt = cnt_q;
    assign locked    = (state_q == LOCKED);
    assign armed     = (state_q == FILL) || (state_q == HUNT);

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

    localparam int N  = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          x = 1'b0;
    logic          cfg_load = 1'b0;
    logic [N-1:0]  cfg_pattern = '0;
    logic [N-1:0]  cfg_mask = '0;
    logic          cfg_overlap = 1'b0;
    logic [CW-1:0] cfg_limit = '0;
    logic          rearm = 1'b0;
    logic          y;
    logic [CW-1:0] match_cnt;
    logic          locked;
    logic          armed;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    // Reference model state: consumed-bit window, counter, mode flags.
    bit            win[$];
    int            m_cnt = 0;
    bit            m_y = 0;
    bit            m_armed = 0;
    bit            m_locked = 0;
    bit [N-1:0]    m_pat = '0;
    bit [N-1:0]    m_mask = '0;
    bit            m_ov = 0;
    int            m_limit = 0;

    always #5 clk = ~clk;

    seq_detector_param #(.N(N), .CW(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .x           (x),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_mask    (cfg_mask),
        .cfg_overlap (cfg_overlap),
        .cfg_limit   (cfg_limit),
        .rearm       (rearm),
        .y           (y),
        .match_cnt   (match_cnt),
        .locked      (locked),
        .armed       (armed)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Window of the last N consumed bits compared position by position:
    // win[0] is the oldest bit and corresponds to pattern bit N-1.
    function automatic bit window_matches();
        if (win.size() < N) return 0;
        for (int i = 0; i < N; i++) begin
            if (m_mask[N-1-i] && (win[i] != m_pat[N-1-i])) return 0;
        end
        return 1;
    endfunction

    task automatic model_edge(input bit iv, input bit xb, input bit ld,
                              input bit ra, input bit rs);
        m_y = 0;
        if (rs) begin
            win.delete(); m_cnt = 0; m_armed = 0; m_locked = 0;
            m_pat = '0; m_mask = '0; m_ov = 0; m_limit = 0;
        end else if (ld) begin
            win.delete(); m_cnt = 0; m_armed = 1; m_locked = 0;
            m_pat = cfg_pattern; m_mask = cfg_mask;
            m_ov = cfg_overlap; m_limit = int'(cfg_limit);
        end else if (ra && (m_armed || m_locked)) begin
            win.delete(); m_cnt = 0; m_armed = 1; m_locked = 0;
        end else if (iv && m_armed) begin
            win.push_back(xb);
            if (win.size() > N) void'(win.pop_front());
            if (window_matches()) begin
                m_y = 1;
                if (m_cnt < (1 << CW) - 1) m_cnt++;
                if (m_limit != 0 && m_cnt == m_limit) begin
                    m_armed = 0; m_locked = 1;
                end else if (!m_ov) begin
                    win.delete();
                end
            end
        end
    endtask

    // One clock: drive inputs, let the edge happen, then compare #1 later.
    task automatic cyc(input bit iv, input bit xb, input bit ld,
                       input bit ra, input bit rs);
        in_valid = iv; x = xb; cfg_load = ld; rearm = ra; reset = rs;
        @(posedge clk);
        model_edge(iv, xb, ld, ra, rs);
        #1;
        check_eq("y", int'(y), int'(m_y));
        check_eq("match_cnt", int'(match_cnt), m_cnt);
        check_eq("locked", int'(locked), int'(m_locked));
        check_eq("armed", int'(armed), int'(m_armed));
        if (y === 1'b1) pulses++;
        in_valid = 0; cfg_load = 0; rearm = 0; reset = 0;
    endtask

    task automatic beat(input bit xb);
        cyc(1'b1, xb, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load(input bit [N-1:0] p, input bit [N-1:0] m,
                        input bit ov, input int lim);
        cfg_pattern = p; cfg_mask = m; cfg_overlap = ov; cfg_limit = CW'(lim);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        pulses = 0;
    endtask

    task automatic stream(input bit [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) beat(bits[i]);
    endtask

    initial begin
        // Reset, then beats with no configuration.
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        check_eq("rst_y", int'(y), 0);
        check_eq("rst_armed", int'(armed), 0);
        pulses = 0;
        for (int i = 0; i < 10; i++) beat(1'($urandom_range(0, 1)));
        check_eq("unarmed_pulses", pulses, 0);
        check_eq("unarmed_cnt", int'(match_cnt), 0);
        $display("scenario: unconfigured stream done");

        // Overlapping 0101.
        load(4'b0101, 4'b1111, 1, 0);
        stream(16'b010101, 6);
        check_eq("ov1_pulses", pulses, 2);
        check_eq("ov1_cnt", int'(match_cnt), 2);
        $display("scenario: overlap 0101 done");

        // Non-overlapping 0101, then two more beats.
        load(4'b0101, 4'b1111, 0, 0);
        stream(16'b010101, 6);
        check_eq("ov0_pulses", pulses, 1);
        check_eq("ov0_cnt", int'(match_cnt), 1);
        stream(16'b01, 2);
        check_eq("ov0_cnt8", int'(match_cnt), 2);
        $display("scenario: non-overlap 0101 done");

        // Lock-out at limit 3, then rearm.
        load(4'b0000, 4'b1111, 1, 3);
        stream(16'b0, 8);
        check_eq("lim_pulses", pulses, 3);
        check_eq("lim_locked", int'(locked), 1);
        check_eq("lim_cnt", int'(match_cnt), 3);
        cyc(0, 0, 0, 1, 0);
        check_eq("rearm_locked", int'(locked), 0);
        check_eq("rearm_cnt", int'(match_cnt), 0);
        pulses = 0;
        stream(16'b0, 4);
        check_eq("rearm_pulses", pulses, 1);
        $display("scenario: limit and rearm done");

        // Don't-care mask 1001.
        load(4'b1001, 4'b1001, 0, 0);
        stream(16'b1001, 4);
        stream(16'b1101, 4);
        check_eq("mask_cnt", int'(match_cnt), 2);
        $display("scenario: masked compare done");

        // Gaps between beats.
        load(4'b0101, 4'b1111, 1, 0);
        for (int i = 3; i >= 0; i--) begin
            cyc(0, 1, 0, 0, 0);
            cyc(0, 0, 0, 0, 0);
            beat(4'b0101 >> i);
        end
        check_eq("gap_cnt", int'(match_cnt), 1);
        check_eq("gap_pulses", pulses, 1);
        $display("scenario: gapped stream done");

        // Reset mid-stream.
        load(4'b0101, 4'b1111, 1, 0);
        stream(16'b010, 3);
        cyc(1, 1, 0, 0, 1);
        check_eq("midrst_armed", int'(armed), 0);
        check_eq("midrst_y", int'(y), 0);
        $display("scenario: mid-stream reset done");

        // cfg_load colliding with a completing beat.
        load(4'b0101, 4'b1111, 1, 0);
        stream(16'b010, 3);
        cyc(1, 1, 1, 0, 0);
        check_eq("ldcol_y", int'(y), 0);
        check_eq("ldcol_cnt", int'(match_cnt), 0);
        $display("scenario: load collision done");

        // Saturation: all-zero mask with no limit.
        load(4'b0000, 4'b0000, 1, 0);
        for (int i = 0; i < 24; i++) beat(1'($urandom_range(0, 1)));
        check_eq("sat_cnt", int'(match_cnt), 15);
        check_eq("sat_y", int'(y), 1);
        $display("scenario: saturation done");

        // Randomised traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 199);
            if (r >= 1 && r < 5) begin
                cfg_pattern = N'($urandom);
                cfg_mask    = N'($urandom | $urandom);
                cfg_overlap = 1'($urandom);
                cfg_limit   = CW'($urandom_range(0, 5));
            end
            cyc($urandom_range(0, 3) != 0, 1'($urandom), r >= 1 && r < 5,
                r >= 5 && r < 9, r == 0);
        end
        $display("scenario: random traffic done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
